// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment digit scanner.
// Anodes are active-low; the decoder expects the inverted nibble.
package seven_seg_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    function automatic logic [DIGIT_W-1:0] hex_invert(input logic [DIGIT_W-1:0] nibble);
        return ~nibble;
    endfunction

    // Only the bit for idx is low, and only if idx falls inside the n real digits.
    function automatic logic [MAX_DIGITS-1:0] onehot_low(input logic [2:0] idx, input int n);
        logic [MAX_DIGITS-1:0] m;
        m = ANODE_OFF;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n && idx == 3'(i)) m[i] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_prescaler.sv
// Slot prescaler: free-running 0..REFRESH_DIV-1 counter with terminal-count
// and first-cycle flags.
module scan_prescaler #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic clk,
    input  logic rst,
    output logic o_tc,
    output logic o_zero
);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc   = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign o_zero = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_cnt <= '0;
        else if (o_tc) r_cnt <= '0;
        else           r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex digit scanner feeding an inverted-nibble 7-seg decoder.
// Optional leading-zero suppression: define LEADING_ZERO_BLANK_EN.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic                          load,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [DIGIT_W-1:0]            hexOut,
    output logic                          frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                                   w_tc;
    logic                                   w_cnt_zero;
    logic                                   w_wrap;
    logic                                   w_lz_blank;
    logic [MAX_DIGITS-1:0]                  w_onehot;
    logic [NUM_DIGITS-1:0]                  w_an_sel;
    logic [NUM_DIGITS-1:0]                  w_an_next;

    logic [IDX_W-1:0]                       r_idx;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     r_pending;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     r_shadow;
    logic                                   r_wrap;
    logic [NUM_DIGITS-1:0]                  r_an;
    logic [DIGIT_W-1:0]                     r_hex;
    logic                                   r_frame_tick;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .o_tc   (w_tc),
        .o_zero (w_cnt_zero)
    );

    assign w_wrap = w_tc && (r_idx == LAST_IDX);

    // Shadow only changes at the frame wrap so a frame never tears; a load on
    // that same cycle bypasses pending so it is not a frame late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_pending <= '0;
            r_shadow  <= '0;
            r_wrap    <= 1'b0;
        end else begin
            if (load) r_pending <= value;
            if (w_tc) r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            if (w_wrap) r_shadow <= load ? value : r_pending;
            r_wrap <= w_wrap;
        end
    end

    assign w_onehot = onehot_low(3'(r_idx), NUM_DIGITS);
    assign w_an_sel = w_onehot[NUM_DIGITS-1:0];

    generate
        if (NUM_DIGITS < MAX_DIGITS) begin : g_hi
            logic w_unused_hi;
            assign w_unused_hi = ^w_onehot[MAX_DIGITS-1:NUM_DIGITS];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // w_zero_above[i]: digit i and every more significant digit are zero.
    logic [NUM_DIGITS-1:0] w_zero_above;
    assign w_zero_above[NUM_DIGITS-1] = (r_shadow[NUM_DIGITS-1] == '0);
    generate
        for (genvar i = 0; i < NUM_DIGITS - 1; i++) begin : g_lz
            assign w_zero_above[i] = (r_shadow[i] == '0) && w_zero_above[i+1];
        end
    endgenerate
    assign w_lz_blank = (r_idx != '0) && w_zero_above[r_idx];
`else
    assign w_lz_blank = 1'b0;
`endif

    always_comb begin
        w_an_next = w_an_sel;
        if (w_cnt_zero || w_lz_blank) w_an_next = ANODE_OFF[NUM_DIGITS-1:0];
    end

    // Registered outputs; frame_tick is delayed once more so it lands on the
    // blank first cycle of digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= ANODE_OFF[NUM_DIGITS-1:0];
            r_hex        <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_hex        <= hex_invert(r_shadow[r_idx]);
            r_frame_tick <= r_wrap;
        end
    end

    assign an         = r_an;
    assign hexOut     = r_hex;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at NUM_DIGITS=4, REFRESH_DIV=4.
// Frame expectations come from a table; reset and timing are hand sequences.
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  an;
    logic [3:0]  hexOut;
    logic        frame_tick;

    int n_cmp = 0;
    int n_bad = 0;

    seven_seg_scanner #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .an         (an),
        .hexOut     (hexOut),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     value;
        bit              wait_load;
        int              load_at;
        logic [3:0][3:0] exp_hex;
        logic [3:0][3:0] exp_an;
    } vec_t;

    vec_t tbl[5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_frame(input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        chk({nm, " frame_tick seen"}, 16'(seen), 16'd1);
    endtask

    // Caller stands on the frame_tick cycle; checks all 16 output cycles.
    task automatic check_frame(input int id, input vec_t e, input logic [15:0] nxt);
        int slot;
        for (int c = 0; c < 16; c++) begin
            slot = c / 4;
            chk($sformatf("f%0d c%0d tick", id, c), 16'(frame_tick), 16'(c == 0));
            chk($sformatf("f%0d c%0d an", id, c), 16'(an),
                (c % 4 == 0) ? 16'hF : 16'(e.exp_an[slot]));
            chk($sformatf("f%0d c%0d hex", id, c), 16'(hexOut), 16'(e.exp_hex[slot]));
            if (c == e.load_at) begin
                value = nxt;
                load  = 1'b1;
            end
            tick();
            load = 1'b0;
        end
    endtask

    initial begin
        int          n;
        logic [15:0] nxt;

`ifdef LEADING_ZERO_BLANK_EN
        tbl[0] = '{16'h1234, 1'b1,  5, 16'hEDCB, 16'h7BDE};
        tbl[1] = '{16'hABCD, 1'b0, 14, 16'h5432, 16'h7BDE};
        tbl[2] = '{16'h00F0, 1'b0, -1, 16'hFF0F, 16'hFFDE};
        tbl[3] = '{16'h0005, 1'b1, -1, 16'hFFFA, 16'hFFFE};
        tbl[4] = '{16'h0000, 1'b1, -1, 16'hFFFF, 16'hFFFE};
`else
        tbl[0] = '{16'h1234, 1'b1,  5, 16'hEDCB, 16'h7BDE};
        tbl[1] = '{16'hABCD, 1'b0, 14, 16'h5432, 16'h7BDE};
        tbl[2] = '{16'h00F0, 1'b0, -1, 16'hFF0F, 16'h7BDE};
        tbl[3] = '{16'h0005, 1'b1, -1, 16'hFFFA, 16'h7BDE};
        tbl[4] = '{16'h0000, 1'b1, -1, 16'hFFFF, 16'h7BDE};
`endif

        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        repeat (3) tick();
        chk("reset an", 16'(an), 16'hF);
        chk("reset hex", 16'(hexOut), 16'hF);
        chk("reset tick", 16'(frame_tick), 16'h0);

        rst = 1'b0;
        tick(); chk("post-rst c0 an", 16'(an), 16'hF);
        tick(); chk("post-rst c1 an", 16'(an), 16'hE);
        tick(); chk("post-rst c2 an", 16'(an), 16'hE);
        tick(); chk("post-rst c3 an", 16'(an), 16'hE);
        tick(); chk("post-rst c4 an", 16'(an), 16'hF);
        tick(); chk("post-rst c5 an", 16'(an), 16'hD);
        chk("post-rst hex", 16'(hexOut), 16'hF);

        // Frame period: consecutive frame_tick pulses 16 cycles apart.
        wait_frame("period");
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            if (frame_tick) break;
        end
        chk("frame period", 16'(n), 16'd16);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].wait_load) begin
                value = tbl[i].value;
                load  = 1'b1;
                tick();
                load = 1'b0;
                wait_frame($sformatf("f%0d", i));
            end
            nxt = (i < 4) ? tbl[i+1].value : 16'h0;
            check_frame(i, tbl[i], nxt);
        end

        // Reset in the middle of showing 1234: blanks at once, value is lost.
        value = 16'h1234;
        load  = 1'b1;
        tick();
        load = 1'b0;
        wait_frame("mid-rst");
        repeat (6) tick();
        chk("pre-rst an", 16'(an), 16'hD);
        chk("pre-rst hex", 16'(hexOut), 16'hC);
        rst = 1'b1;
        #1;
        chk("async rst an", 16'(an), 16'hF);
        chk("async rst hex", 16'(hexOut), 16'hF);
        chk("async rst tick", 16'(frame_tick), 16'h0);
        tick();
        rst = 1'b0;
        tick(); chk("mid-rst c0 an", 16'(an), 16'hF);
        tick(); chk("mid-rst c1 an", 16'(an), 16'hE);
        chk("mid-rst c1 hex", 16'(hexOut), 16'hF);
        wait_frame("after-rst");
        chk("after-rst d0 hex", 16'(hexOut), 16'hF);
        repeat (5) tick();
        chk("after-rst d1 hex", 16'(hexOut), 16'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
